ahb_lite_gpio: RTL and testbench

AHB_LITE_GPIO -- requirements
Module: ahb_lite_gpio

---
 rtl/ahb_gpio_pkg.sv | 41 ++++
 rtl/gpio_debounce.sv | 57 +++++
 rtl/ahb_lite_gpio.sv | 166 ++++++++++++++++
 tb/tb_ahb_lite_gpio.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_gpio_pkg.sv
// ahb_gpio_pkg: register offsets, HTRANS encodings and register-index enum
// shared by the AHB-Lite GPIO slave and its debouncer.
package ahb_gpio_pkg;

    // AHB transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Byte offsets of the register map
    localparam logic [7:0] OFF_OUT      = 8'h00;
    localparam logic [7:0] OFF_IN       = 8'h04;
    localparam logic [7:0] OFF_IRQ_MASK = 8'h08;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h0C;
    localparam logic [7:0] OFF_DBNC     = 8'h10;

    // Word index as decoded from haddr[4:2]
    typedef enum logic [2:0] {
        REG_OUT      = OFF_OUT[4:2],
        REG_IN       = OFF_IN[4:2],
        REG_IRQ_MASK = OFF_IRQ_MASK[4:2],
        REG_IRQ_STAT = OFF_IRQ_STAT[4:2],
        REG_DBNC     = OFF_DBNC[4:2],
        REG_RSVD5    = 3'd5,
        REG_RSVD6    = 3'd6,
        REG_RSVD7    = 3'd7
    } reg_idx_e;

    // NONSEQ and SEQ start a transfer; IDLE and BUSY do not
    function automatic logic htrans_active(input logic [1:0] t);
        logic act;
        case (t)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
            default:                   act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: one input bit through a 2-flop synchronizer, then a
// stability counter. The output level follows the synchronized value only
// after it has differed from the current level for DBNC_CYCLES consecutive
// cycles; any cycle of agreement restarts the count.
module gpio_debounce
    import ahb_gpio_pkg::*;
#(
    parameter int DBNC_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    localparam logic [15:0] CNT_LAST = 16'(DBNC_CYCLES - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic [15:0] r_cnt;

    logic w_diff;
    logic w_done;

    assign w_diff = (r_sync2 != r_level);
    // The cycle whose edge flips the level: the DBNC_CYCLES-th differing cycle
    assign w_done = w_diff && (r_cnt == CNT_LAST);

    // Synchronize, count differing cycles, and commit the new level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            if (w_done) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    // High in the cycle before the level goes 0->1, so a status bit set on
    // this pulse changes at the same edge as the level itself
    assign o_rise  = w_done & r_sync2;

endmodule

// File: rtl/ahb_lite_gpio.sv
// ahb_lite_gpio: zero-wait-state AHB-Lite slave with OUT_W LED outputs and
// IN_W debounced button inputs. Defining GPIO_IRQ_EN adds rising-edge
// interrupt status/mask registers and a level irq output; without it the
// irq registers read 0 and irq is tied low.
module ahb_lite_gpio
    import ahb_gpio_pkg::*;
#(
    parameter int DBNC_CYCLES = 16,
    parameter int OUT_W       = 6,
    parameter int IN_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsel,
    input  logic [31:0]      haddr,
    input  logic [1:0]       htrans,
    input  logic             hwrite,
    input  logic [2:0]       hsize,
    input  logic [31:0]      hwdata,
    input  logic             hready_in,
    output logic [31:0]      hrdata,
    output logic             hreadyout,
    output logic             hresp,
    input  logic [IN_W-1:0]  gpio_in,
    output logic [OUT_W-1:0] gpio_out,
    output logic             irq
);

    // Data-phase state captured from the address phase
    logic     r_dp_valid;
    logic     r_dp_write;
    reg_idx_e r_dp_idx;
    logic [2:0] r_dp_size;
    logic     r_dp_lane0;

    logic [OUT_W-1:0] r_out;

    logic w_accept;
    logic w_wr;
    logic w_wr_out;
    logic w_wr_mask;
    logic w_wr_stat;

    logic [IN_W-1:0] w_deb;
    logic [IN_W-1:0] w_rise;
    logic [IN_W-1:0] w_mask;
    logic [IN_W-1:0] w_stat;
    logic            w_irq;
    logic [31:0]     w_rdata;
    logic            w_unused;

    assign w_accept = hsel & htrans_active(htrans) & hready_in;

    // Address phase -> data phase pipeline register; reset drops any transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_idx   <= REG_OUT;
            r_dp_size  <= 3'd0;
            r_dp_lane0 <= 1'b0;
        end else if (hready_in) begin
            r_dp_valid <= w_accept;
            r_dp_write <= hwrite;
            r_dp_idx   <= reg_idx_e'(haddr[4:2]);
            r_dp_size  <= hsize;
            r_dp_lane0 <= (haddr[1:0] == 2'b00);
        end
    end

    // Writes commit at the edge ending the data phase, only if byte lane 0 is in it
    assign w_wr      = r_dp_valid & r_dp_write & r_dp_lane0;
    assign w_wr_out  = w_wr & (r_dp_idx == REG_OUT);
    assign w_wr_mask = w_wr & (r_dp_idx == REG_IRQ_MASK);
    assign w_wr_stat = w_wr & (r_dp_idx == REG_IRQ_STAT);

    // LED output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else if (w_wr_out) begin
            r_out <= hwdata[OUT_W-1:0];
        end
    end

    for (genvar g = 0; g < IN_W; g++) begin : g_dbnc
        gpio_debounce #(
            .DBNC_CYCLES(DBNC_CYCLES)
        ) u_dbnc (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_async(gpio_in[g]),
            .o_level(w_deb[g]),
            .o_rise (w_rise[g])
        );
    end

`ifdef GPIO_IRQ_EN
    logic [IN_W-1:0] r_mask;
    logic [IN_W-1:0] r_stat;
    logic            r_irq;
    logic [IN_W-1:0] w_clr;

    assign w_clr = w_wr_stat ? hwdata[IN_W-1:0] : '0;

    // Interrupt mask register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
        end else if (w_wr_mask) begin
            r_mask <= hwdata[IN_W-1:0];
        end
    end

    // Sticky rising-edge status; a new edge beats a same-cycle W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat <= '0;
        end else begin
            r_stat <= (r_stat & ~w_clr) | w_rise;
        end
    end

    // Registered interrupt level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_stat & r_mask);
        end
    end

    assign w_mask = r_mask;
    assign w_stat = r_stat;
    assign w_irq  = r_irq;
`else
    assign w_mask = '0;
    assign w_stat = '0;
    assign w_irq  = 1'b0;
`endif

    // Read mux: zero-extended register value during a read data phase only
    always_comb begin
        w_rdata = 32'd0;
        if (r_dp_valid && !r_dp_write) begin
            case (r_dp_idx)
                REG_OUT:      w_rdata = 32'(r_out);
                REG_IN:       w_rdata = 32'(w_deb);
                REG_IRQ_MASK: w_rdata = 32'(w_mask);
                REG_IRQ_STAT: w_rdata = 32'(w_stat);
                REG_DBNC:     w_rdata = 32'(DBNC_CYCLES);
                default:      w_rdata = 32'd0;
            endcase
        end
    end

    assign hrdata    = rst ? 32'd0 : w_rdata;
    assign hreadyout = 1'b1;
    assign hresp     = 1'b0;
    assign gpio_out  = r_out;
    assign irq       = w_irq;

    // Address/data bits outside the decoded fields, and hsize, carry no meaning here
    assign w_unused = ^{haddr, hwdata, r_dp_size, w_rise, w_wr_mask, w_wr_stat};

endmodule

// File: tb/tb_ahb_lite_gpio.sv
// tb_ahb_lite_gpio: directed self-checking bench for ahb_lite_gpio with
// default parameters (DBNC_CYCLES=16, OUT_W=6, IN_W=5). Follows GPIO_IRQ_EN
// the same way the design does.
module tb_ahb_lite_gpio;
    import ahb_gpio_pkg::*;

    localparam int DBNC  = 16;
    localparam int OUT_W = 6;
    localparam int IN_W  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             hsel;
    logic [31:0]      haddr;
    logic [1:0]       htrans;
    logic             hwrite;
    logic [2:0]       hsize;
    logic [31:0]      hwdata;
    logic             hready_in;
    logic [31:0]      hrdata;
    logic             hreadyout;
    logic             hresp;
    logic [IN_W-1:0]  gpio_in;
    logic [OUT_W-1:0] gpio_out;
    logic             irq;

    int n_pass  = 0;
    int n_total = 0;

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    ahb_lite_gpio #(
        .DBNC_CYCLES(DBNC),
        .OUT_W      (OUT_W),
        .IN_W       (IN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hsel     (hsel),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hwdata   (hwdata),
        .hready_in(hready_in),
        .hrdata   (hrdata),
        .hreadyout(hreadyout),
        .hresp    (hresp),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    // ---------------- driver tasks (all start and end 1ns after a rising edge)
    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        haddr  = 32'd0;
        hsize  = 3'b010;
    endtask

    task automatic addr_phase(input logic wr, input logic [7:0] off);
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        hwrite = wr;
        haddr  = {24'd0, off};
        hsize  = 3'b010;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ahb_write(input logic [7:0] off, input logic [31:0] data);
        addr_phase(1'b1, off);
        tick(1);
        bus_idle();
        hwdata = data;
        tick(1);
    endtask

    task automatic ahb_read(input logic [7:0] off, output logic [31:0] data);
        addr_phase(1'b0, off);
        tick(1);
        bus_idle();
        data = hrdata;
        tick(1);
    endtask

    // ---------------- tests
    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1;
        tick(3);
        n_total++;
        if (gpio_out !== 6'h00) $display("FAIL rst_gpio_out: got %h expected %h", gpio_out, 6'h00);
        else n_pass++;
        n_total++;
        if (irq !== 1'b0) $display("FAIL rst_irq: got %b expected 0", irq);
        else n_pass++;
        n_total++;
        if (hrdata !== 32'd0) $display("FAIL rst_hrdata: got %h expected 0", hrdata);
        else n_pass++;
        n_total++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0)
            $display("FAIL rst_resp: got ready=%b resp=%b expected 1/0", hreadyout, hresp);
        else n_pass++;
        rst = 1'b0;
        tick(1);
        ahb_read(OFF_IN, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL rst_in: got %h expected 0", rd);
        else n_pass++;
        ahb_read(OFF_IRQ_MASK, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL rst_mask: got %h expected 0", rd);
        else n_pass++;
        ahb_read(OFF_IRQ_STAT, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL rst_stat: got %h expected 0", rd);
        else n_pass++;
        ahb_read(OFF_DBNC, rd);
        n_total++;
        if (rd !== 32'd16) $display("FAIL dbnc_reg: got %h expected %h", rd, 32'd16);
        else n_pass++;
    endtask

    task automatic test_write_out();
        logic [31:0] rd;
        addr_phase(1'b1, OFF_OUT);
        tick(1);
        bus_idle();
        hwdata = 32'h0000_002A;
        n_total++;
        if (gpio_out !== 6'h00) $display("FAIL out_before_edge: got %h expected %h", gpio_out, 6'h00);
        else n_pass++;
        tick(1);
        n_total++;
        if (gpio_out !== 6'h2A) $display("FAIL out_after_write: got %h expected %h", gpio_out, 6'h2A);
        else n_pass++;
        ahb_read(OFF_OUT, rd);
        n_total++;
        if (rd !== 32'h0000_002A) $display("FAIL out_readback: got %h expected %h", rd, 32'h2A);
        else n_pass++;
        // haddr[1:0]=1 leaves byte lane 0 out of the transfer
        ahb_write(8'h01, 32'h0000_003F);
        n_total++;
        if (gpio_out !== 6'h2A) $display("FAIL out_lane0: got %h expected %h", gpio_out, 6'h2A);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        addr_phase(1'b1, OFF_OUT);
        tick(1);
        hwdata = 32'h0000_0015;
        addr_phase(1'b0, OFF_OUT);
        tick(1);
        bus_idle();
        rd = hrdata;
        n_total++;
        if (rd !== 32'h0000_0015) $display("FAIL b2b_read: got %h expected %h", rd, 32'h15);
        else n_pass++;
        n_total++;
        if (gpio_out !== 6'h15) $display("FAIL b2b_out: got %h expected %h", gpio_out, 6'h15);
        else n_pass++;
        tick(1);
    endtask

    task automatic test_no_effect();
        logic [31:0] rd;
        logic        sel_tab  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0]  trans_tab[4] = '{HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_NONSEQ};
        logic        rdy_tab  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        ahb_write(OFF_IN, 32'h0000_001F);
        ahb_read(OFF_IN, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL ro_in_write: got %h expected 0", rd);
        else n_pass++;
        ahb_write(8'h18, 32'hFFFF_FFFF);
        ahb_read(8'h18, rd);
        n_total++;
        if (rd !== 32'd0) $display("FAIL rsvd_read: got %h expected 0", rd);
        else n_pass++;
        n_total++;
        if (gpio_out !== 6'h15) $display("FAIL rsvd_out: got %h expected %h", gpio_out, 6'h15);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            hsel      = sel_tab[c];
            htrans    = trans_tab[c];
            hwrite    = 1'b1;
            haddr     = {24'd0, OFF_OUT};
            hready_in = rdy_tab[c];
            tick(1);
            n_total++;
            if (hreadyout !== 1'b1 || hresp !== 1'b0)
                $display("FAIL noacc_resp_a%0d: got ready=%b resp=%b expected 1/0", c, hreadyout, hresp);
            else n_pass++;
            bus_idle();
            hready_in = 1'b1;
            hwdata    = 32'h0000_003F;
            tick(1);
            n_total++;
            if (hreadyout !== 1'b1 || hresp !== 1'b0)
                $display("FAIL noacc_resp_d%0d: got ready=%b resp=%b expected 1/0", c, hreadyout, hresp);
            else n_pass++;
            n_total++;
            if (gpio_out !== 6'h15) $display("FAIL noacc_out%0d: got %h expected %h", c, gpio_out, 6'h15);
            else n_pass++;
        end
    endtask

    task automatic test_reset_abort();
        // Reset coincides with the address phase; the write must never land
        addr_phase(1'b1, OFF_OUT);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        bus_idle();
        hwdata = 32'h0000_003F;
        tick(1);
        n_total++;
        if (gpio_out !== 6'h00) $display("FAIL abort_out: got %h expected %h", gpio_out, 6'h00);
        else n_pass++;
        tick(1);
        n_total++;
        if (gpio_out !== 6'h00) $display("FAIL abort_out_late: got %h expected %h", gpio_out, 6'h00);
        else n_pass++;
    endtask

    task automatic test_debounce();
        logic [31:0] seen;
        logic [31:0] rd;
        // Continuous reads of IN: hrdata after edge k shows the level after edge k
        addr_phase(1'b0, OFF_IN);
        tick(1);
        gpio_in[0] = 1'b1;
        seen = 32'd0;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (k == 10) gpio_in[0] = 1'b0;
            seen |= hrdata;
        end
        n_total++;
        if (seen !== 32'd0) $display("FAIL dbnc_glitch: got %h expected 0", seen);
        else n_pass++;
        gpio_in[0] = 1'b1;
        seen = 32'd0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (k <= 17) seen |= hrdata;
            if (k == 18) begin
                n_total++;
                if (hrdata !== 32'h1) $display("FAIL dbnc_rise_at18: got %h expected %h", hrdata, 32'h1);
                else n_pass++;
            end
        end
        n_total++;
        if (seen !== 32'd0) $display("FAIL dbnc_rise_early: got %h expected 0", seen);
        else n_pass++;
        gpio_in[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (k == 17) begin
                n_total++;
                if (hrdata !== 32'h1) $display("FAIL dbnc_fall_at17: got %h expected %h", hrdata, 32'h1);
                else n_pass++;
            end
            if (k == 18) begin
                n_total++;
                if (hrdata !== 32'h0) $display("FAIL dbnc_fall_at18: got %h expected 0", hrdata);
                else n_pass++;
            end
        end
        bus_idle();
        tick(1);
        // Two other bits together
        gpio_in = 5'b10100;
        tick(22);
        ahb_read(OFF_IN, rd);
        n_total++;
        if (rd !== 32'h14) $display("FAIL dbnc_multi: got %h expected %h", rd, 32'h14);
        else n_pass++;
        gpio_in = '0;
        tick(22);
        ahb_read(OFF_IN, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL dbnc_multi_off: got %h expected 0", rd);
        else n_pass++;
    endtask

`ifdef GPIO_IRQ_EN
    task automatic test_irq();
        logic [31:0] rd;
        ahb_write(OFF_IRQ_STAT, 32'h1F);
        ahb_write(OFF_IRQ_MASK, 32'h01);
        ahb_read(OFF_IRQ_MASK, rd);
        n_total++;
        if (rd !== 32'h1) $display("FAIL irq_mask_rd: got %h expected %h", rd, 32'h1);
        else n_pass++;
        addr_phase(1'b0, OFF_IRQ_STAT);
        tick(1);
        gpio_in[0] = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick(1);
            if (k == 17) begin
                n_total++;
                if (hrdata !== 32'h0 || irq !== 1'b0)
                    $display("FAIL irq_k17: got stat=%h irq=%b expected 0/0", hrdata, irq);
                else n_pass++;
            end
            if (k == 18) begin
                n_total++;
                if (hrdata !== 32'h1 || irq !== 1'b0)
                    $display("FAIL irq_k18: got stat=%h irq=%b expected 1/0", hrdata, irq);
                else n_pass++;
            end
            if (k == 19) begin
                n_total++;
                if (irq !== 1'b1) $display("FAIL irq_k19: got %b expected 1", irq);
                else n_pass++;
            end
        end
        bus_idle();
        ahb_write(OFF_IRQ_STAT, 32'h01);
        n_total++;
        if (irq !== 1'b1) $display("FAIL irq_clr_lag: got %b expected 1", irq);
        else n_pass++;
        tick(1);
        n_total++;
        if (irq !== 1'b0) $display("FAIL irq_clr: got %b expected 0", irq);
        else n_pass++;
        ahb_read(OFF_IRQ_STAT, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL irq_stat_clr: got %h expected 0", rd);
        else n_pass++;
        gpio_in[0] = 1'b0;
        tick(22);
        ahb_read(OFF_IRQ_STAT, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL irq_fall_nostat: got %h expected 0", rd);
        else n_pass++;
    endtask

    task automatic test_irq_collision();
        logic [31:0] rd;
        gpio_in[0] = 1'b1;
        tick(16);
        addr_phase(1'b1, OFF_IRQ_STAT);
        tick(1);
        bus_idle();
        hwdata = 32'h01;
        tick(1);
        ahb_read(OFF_IRQ_STAT, rd);
        n_total++;
        if (rd !== 32'h1) $display("FAIL irq_collision_stat: got %h expected %h", rd, 32'h1);
        else n_pass++;
        n_total++;
        if (irq !== 1'b1) $display("FAIL irq_collision_irq: got %b expected 1", irq);
        else n_pass++;
        ahb_write(OFF_IRQ_STAT, 32'h01);
        gpio_in[0] = 1'b0;
        tick(22);
        ahb_write(OFF_IRQ_MASK, 32'h0);
    endtask
`else
    task automatic test_irq_disabled();
        logic [31:0] rd;
        logic        irq_seen;
        ahb_write(OFF_IRQ_MASK, 32'h1F);
        ahb_read(OFF_IRQ_MASK, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL noirq_mask: got %h expected 0", rd);
        else n_pass++;
        gpio_in[0] = 1'b1;
        irq_seen = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            tick(1);
            irq_seen |= irq;
        end
        n_total++;
        if (irq_seen !== 1'b0) $display("FAIL noirq_irq: got %b expected 0", irq_seen);
        else n_pass++;
        ahb_read(OFF_IRQ_STAT, rd);
        n_total++;
        if (rd !== 32'h0) $display("FAIL noirq_stat: got %h expected 0", rd);
        else n_pass++;
        ahb_read(OFF_IN, rd);
        n_total++;
        if (rd !== 32'h1) $display("FAIL noirq_in: got %h expected %h", rd, 32'h1);
        else n_pass++;
        gpio_in[0] = 1'b0;
        tick(22);
    endtask
`endif

    // ---------------- sequence and report
    initial begin
        rst       = 1'b1;
        hready_in = 1'b1;
        hwdata    = 32'd0;
        gpio_in   = '0;
        bus_idle();
        tick(1);
        test_reset();
        test_write_out();
        test_back_to_back();
        test_no_effect();
        test_reset_abort();
        test_debounce();
`ifdef GPIO_IRQ_EN
        test_irq();
        test_irq_collision();
`else
        test_irq_disabled();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
